// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU control with RV32M support.
// Holds the ALUOp encodings, ALU Operation codes, Funct7 classes, the
// M-extension operation enum, the multiply/divide FSM state enum and
// helpers that classify operand signedness per M op.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;  // LW/SW/AUIPC
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // branches
  localparam logic [1:0] ALUOP_RI  = 2'b10;  // R/I-type arithmetic
  localparam logic [1:0] ALUOP_JL  = 2'b11;  // JAL/LUI

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLTI = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BNE  = 4'b1100;
  localparam logic [3:0] OP_BLT  = 4'b1101;
  localparam logic [3:0] OP_BGE  = 4'b1110;
  localparam logic [3:0] OP_LUI  = 4'b1111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM,    MD_REMU
  } muldiv_op_e;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // MUL low half is sign-agnostic, so it is grouped with the signed ops.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_iter.sv
// Iterative RV32M multiply/divide engine.
// Ports: clk/reset (sync, active-high); i_start (M op presented),
// i_flush (abort), i_funct3 (op select), i_a/i_b (operands);
// o_stall, o_result_valid (one-cycle strobe), o_result (held).
// Multiply is shift-add on operand magnitudes, divide is restoring
// division; signs are reapplied when the last step retires.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies retire as soon as the
// remaining multiplier bits are all zero.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_stall,
  output logic             o_result_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  state_e             r_state, w_state_nxt;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_result;
  muldiv_op_e         r_op;
  logic               r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0] r_acc;   // mul: partial product; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_opa;   // mul: multiplicand shifting left; div: divisor in low half
  logic [WIDTH-1:0]   r_opb;   // mul: multiplier shifting right

  muldiv_op_e         w_op;
  logic               w_is_div, w_sa, w_sb, w_div_zero, w_ovf, w_special, w_last;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_special_res, w_opb_step, w_final;
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_acc_mul, w_acc_div, w_acc_step, w_opa_step, w_prod;

  // Operand capture: magnitudes and special-case detection
  always_comb begin
    w_op       = muldiv_op_e'(i_funct3);
    w_is_div   = i_funct3[2];
    w_sa       = op_a_signed(w_op) & i_a[WIDTH-1];
    w_sb       = op_b_signed(w_op) & i_b[WIDTH-1];
    w_mag_a    = cond_neg_w(w_sa, i_a);
    w_mag_b    = cond_neg_w(w_sb, i_b);
    w_div_zero = w_is_div && (i_b == '0);
    w_ovf      = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                 (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);
    w_special  = w_div_zero || w_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (w_div_zero) w_special_res = i_funct3[1] ? i_a : '1;
    else            w_special_res = i_funct3[1] ? '0 : i_a;
  end

  // Iteration step and final sign fix-up
  always_comb begin
    w_acc_mul  = r_opb[0] ? (r_acc + r_opa) : r_acc;
    w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff     = w_rem_sh - {1'b0, r_opa[WIDTH-1:0]};
    // borrow out of the top bit means the trial subtract failed
    if (!w_diff[WIDTH]) w_acc_div = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else                w_acc_div = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    w_acc_step = r_op[2] ? w_acc_div : w_acc_mul;
    w_opa_step = r_op[2] ? r_opa : (r_opa << 1);
    w_opb_step = r_opb >> 1;
    w_prod     = cond_neg_2w(r_neg_q, w_acc_step);
    case (r_op)
      MD_MUL:                      w_final = w_prod[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:             w_final = cond_neg_w(r_neg_q, w_acc_step[WIDTH-1:0]);
      default:                     w_final = cond_neg_w(r_neg_r, w_acc_step[2*WIDTH-1:WIDTH]);
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    w_last = (r_count == LAST) || (!r_op[2] && (w_opb_step == '0));
`else
    w_last = (r_count == LAST);
`endif
  end

  // Next-state and stall
  always_comb begin
    w_state_nxt = r_state;
    o_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        o_stall = i_start;
        if (i_start && !i_flush) w_state_nxt = w_special ? DONE : CALC;
      end
      CALC: begin
        o_stall = 1'b1;
        if (i_flush)     w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control registers and issued result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE)      r_count <= '0;
      else if (r_state == CALC) r_count <= r_count + CW'(1);
      if ((r_state == IDLE) && i_start && !i_flush && w_special) r_result <= w_special_res;
      else if ((r_state == CALC) && !i_flush && w_last)          r_result <= w_final;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && i_start && !i_flush) begin
      r_op    <= w_op;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      r_acc   <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : '0;
      r_opa   <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_b : w_mag_a)};
      r_opb   <= w_mag_b;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_step;
      r_opa <= w_opa_step;
      r_opb <= w_opb_step;
    end
  end

  assign o_result_valid = (r_state == DONE);
  assign o_result       = r_result;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control: decodes ALUOp/Funct3/Funct7 into the 4-bit ALU
// Operation code, flags undecodable combinations, and runs RV32M ops on
// the iterative engine (muldiv_iter) when M_EN=1.
// Ports: clk, reset (sync, active-high); ALUOp, Funct7, Funct3, valid_i,
// flush, a, b in; Operation, illegal (combinational), stall, result,
// result_valid out.
// Optional macro MULDIV_EARLY_OUT_EN enables multiply early-out in the engine.
module alu_ctrl_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int M_EN  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             valid_i,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       Operation,
  output logic             illegal,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  logic w_mop;

  assign w_mop = valid_i && (ALUOp == ALUOP_RI) && (Funct7 == F7_MULDIV) && (M_EN != 0);

  always_comb begin
    Operation = OP_ADD;
    illegal   = 1'b0;
    case (ALUOp)
      ALUOP_MEM: Operation = OP_ADD;
      ALUOP_JL:  Operation = OP_LUI;
      ALUOP_BR: begin
        case (Funct3)
          3'b000:  Operation = OP_BEQ;
          3'b001:  Operation = OP_BNE;
          3'b100:  Operation = OP_BLT;
          3'b101:  Operation = OP_BGE;
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        if (w_mop) begin
          Operation = OP_ADD;
        end else if (Funct7 == F7_BASE) begin
          case (Funct3)
            3'b000:  Operation = OP_ADD;
            3'b001:  Operation = OP_SLL;
            3'b010:  Operation = OP_SLT;
            3'b100:  Operation = OP_XOR;
            3'b101:  Operation = OP_SRL;
            3'b110:  Operation = OP_OR;
            3'b111:  Operation = OP_AND;
            default: illegal = 1'b1;
          endcase
        end else if (Funct7 == F7_ALT) begin
          case (Funct3)
            3'b000:  Operation = OP_SUB;
            3'b101:  Operation = OP_SRA;
            default: illegal = 1'b1;
          endcase
        end else if (Funct7 != F7_MULDIV) begin
          // I-type: Funct7 field carries immediate bits
          case (Funct3)
            3'b000:  Operation = OP_ADDI;
            3'b010:  Operation = OP_SLTI;
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
    endcase
  end

  generate
    if (M_EN != 0) begin : g_muldiv
      muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk            (clk),
        .reset          (reset),
        .i_start        (w_mop),
        .i_flush        (flush),
        .i_funct3       (Funct3),
        .i_a            (a),
        .i_b            (b),
        .o_stall        (stall),
        .o_result_valid (result_valid),
        .o_result       (result)
      );
    end else begin : g_no_muldiv
      assign stall        = 1'b0;
      assign result_valid = 1'b0;
      assign result       = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
module tb_alu_ctrl_muldiv;

  logic        clk = 1'b0;
  logic        reset, valid_i, flush;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] a, b, result;
  logic [3:0]  Operation;
  logic        illegal, stall, result_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_muldiv #(.WIDTH(32), .M_EN(1)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .valid_i(valid_i), .flush(flush), .a(a), .b(b),
    .Operation(Operation), .illegal(illegal), .stall(stall),
    .result(result), .result_valid(result_valid)
  );

  typedef struct {
    logic [1:0] aluop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] op;
    logic       ill;
  } dec_vec_t;

  dec_vec_t dv[$];

  task automatic addv(input logic [1:0] al, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [3:0] op, input logic ill);
    dec_vec_t v;
    v.aluop = al; v.f7 = f7; v.f3 = f3; v.op = op; v.ill = ill;
    dv.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one M op at cycle 0 and wait for its result strobe.
  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] av,
                         input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_res);
    int   cyc;
    logic seen, stall_bad;
    @(posedge clk); #1;
    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = f3; a = av; b = bv; valid_i = 1'b1;
    @(negedge clk);
    check({name, " stall c0"}, {31'b0, stall}, 32'd1);
    check({name, " decode"}, {27'b0, illegal, Operation}, 32'd0);
    cyc = 0; seen = 1'b0; stall_bad = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      cyc++;
      @(negedge clk);
      if (result_valid) seen = 1'b1;
      else if (!stall) stall_bad = 1'b1;
    end
    check({name, " latency"}, cyc, exp_lat);
    check({name, " result"}, result, exp_res);
    check({name, " stall busy"}, {31'b0, stall_bad}, 32'd0);
    check({name, " stall done"}, {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, " strobe 1cyc"}, {31'b0, result_valid}, 32'd0);
    check({name, " hold"}, result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c, pulses, p1, p2;
    logic rv;
    logic [31:0] r1, r2, st34;

    reset = 1'b1; valid_i = 1'b0; flush = 1'b0;
    ALUOp = 2'b00; Funct7 = 7'h00; Funct3 = 3'b000; a = '0; b = '0;

    addv(2'b00, 7'h00, 3'b010, 4'b0000, 1'b0);
    addv(2'b11, 7'h00, 3'b000, 4'b1111, 1'b0);
    addv(2'b01, 7'h00, 3'b000, 4'b1011, 1'b0);
    addv(2'b01, 7'h00, 3'b001, 4'b1100, 1'b0);
    addv(2'b01, 7'h00, 3'b100, 4'b1101, 1'b0);
    addv(2'b01, 7'h00, 3'b101, 4'b1110, 1'b0);
    addv(2'b01, 7'h00, 3'b010, 4'b0000, 1'b1);
    addv(2'b01, 7'h00, 3'b111, 4'b0000, 1'b1);
    addv(2'b10, 7'h00, 3'b000, 4'b0000, 1'b0);
    addv(2'b10, 7'h00, 3'b001, 4'b0101, 1'b0);
    addv(2'b10, 7'h00, 3'b010, 4'b1001, 1'b0);
    addv(2'b10, 7'h00, 3'b011, 4'b0000, 1'b1);
    addv(2'b10, 7'h00, 3'b100, 4'b0100, 1'b0);
    addv(2'b10, 7'h00, 3'b101, 4'b0110, 1'b0);
    addv(2'b10, 7'h00, 3'b110, 4'b0011, 1'b0);
    addv(2'b10, 7'h00, 3'b111, 4'b0010, 1'b0);
    addv(2'b10, 7'h20, 3'b000, 4'b0001, 1'b0);
    addv(2'b10, 7'h20, 3'b101, 4'b0111, 1'b0);
    addv(2'b10, 7'h20, 3'b001, 4'b0000, 1'b1);
    addv(2'b10, 7'h13, 3'b000, 4'b1010, 1'b0);
    addv(2'b10, 7'h13, 3'b010, 4'b1000, 1'b0);
    addv(2'b10, 7'h13, 3'b001, 4'b0000, 1'b1);
    addv(2'b10, 7'h7F, 3'b111, 4'b0000, 1'b1);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset result_valid", {31'b0, result_valid}, 32'd0);
    check("reset result", result, 32'd0);

    for (int i = 0; i < dv.size(); i++) begin
      @(posedge clk); #1;
      ALUOp = dv[i].aluop; Funct7 = dv[i].f7; Funct3 = dv[i].f3;
      @(negedge clk);
      check($sformatf("dec[%0d] Operation", i), {28'b0, Operation}, {28'b0, dv[i].op});
      check($sformatf("dec[%0d] illegal", i), {31'b0, illegal}, {31'b0, dv[i].ill});
      check($sformatf("dec[%0d] stall", i), {31'b0, stall}, 32'd0);
    end

    run_mop("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB);
    run_mop("MULHU max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
    run_mop("MULHSU -1*2",   3'b010, 32'hFFFFFFFF, 32'd2,        33, 32'hFFFFFFFF);
    run_mop("MULH -1*-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000);
    run_mop("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000);
    run_mop("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 1,  32'h00000000);
    run_mop("DIVU by0",      3'b101, 32'd100,      32'd0,        1,  32'hFFFFFFFF);
    run_mop("REMU by0",      3'b111, 32'd100,      32'd0,        1,  32'd100);
    run_mop("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF);
    run_mop("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD);
    run_mop("DIVU 1000/7",   3'b101, 32'd1000,     32'd7,        33, 32'd142);

    // Flush at cycle 10, nothing issued afterwards
    @(posedge clk); #1;
    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'b100; a = 32'd1000; b = 32'd7; valid_i = 1'b1;
    rv = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      valid_i = 1'b0; flush = (k == 10);
      @(negedge clk);
      if (result_valid) rv = 1'b1;
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush stall c11", {31'b0, stall}, 32'd0);
    if (result_valid) rv = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) rv = 1'b1;
    end
    check("flush no result_valid", {31'b0, rv}, 32'd0);

    // Flush at cycle 10, DIVU issued at cycle 11
    @(posedge clk); #1;
    Funct3 = 3'b100; a = 32'd1000; b = 32'd7; valid_i = 1'b1;
    rv = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      valid_i = 1'b0; flush = (k == 10);
      @(negedge clk);
      if (result_valid) rv = 1'b1;
    end
    @(posedge clk); #1;
    flush = 1'b0; Funct3 = 3'b101; valid_i = 1'b1;
    c = 11;
    @(negedge clk);
    while (!result_valid && c < 120) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      c++;
      @(negedge clk);
    end
    check("flush early strobe", {31'b0, rv}, 32'd0);
    check("post-flush DIVU cycle", c, 32'd44);
    check("post-flush DIVU result", result, 32'd142);

    // Reset mid-CALC
    @(posedge clk); #1;
    Funct3 = 3'b000; a = 32'd9; b = 32'd9; valid_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      valid_i = 1'b0; reset = (k == 5);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset stall", {31'b0, stall}, 32'd0);
    check("midreset result", result, 32'd0);
    rv = result_valid;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) rv = 1'b1;
    end
    check("midreset no result_valid", {31'b0, rv}, 32'd0);

    // Back-to-back MULs with valid_i held through DONE
    @(posedge clk); #1;
    Funct3 = 3'b000; a = 32'd3; b = 32'd5; valid_i = 1'b1;
    pulses = 0; p1 = -1; p2 = -1; r1 = '0; r2 = '0; st34 = '0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k == 34) b = 32'd6;
      if (k == 35) valid_i = 1'b0;
      @(negedge clk);
      if (k == 34) st34 = {31'b0, stall};
      if (result_valid) begin
        pulses++;
        if (pulses == 1) begin p1 = k; r1 = result; end
        if (pulses == 2) begin p2 = k; r2 = result; end
      end
    end
    check("b2b pulses", pulses, 32'd2);
    check("b2b first cycle", p1, 32'd33);
    check("b2b first result", r1, 32'd15);
    check("b2b restart stall", st34, 32'd1);
    check("b2b second cycle", p2, 32'd67);
    check("b2b second result", r2, 32'd18);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
